// File: rtl/seq_pkg.sv
// Shared encodings for the fetch sequencer: instruction field positions,
// control/branch opcodes, FSM states and an instruction classifier.
package seq_pkg;

    localparam int INSTR_BITS = 19;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 2;
    localparam int RB_LSB   = 3;
    localparam int RB_MSB   = 6;
    localparam int RA_LSB   = 7;
    localparam int RA_MSB   = 10;
    localparam int TGT_LSB  = 11;
    localparam int TGT_MSB  = 14;
    localparam int FUNC_LSB = 15;
    localparam int FUNC_MSB = 18;

    localparam logic [2:0] TYPE_BRANCH = 3'b100;
    localparam logic [2:0] TYPE_CTRL   = 3'b101;

    localparam logic [3:0] F_JMP  = 4'b0000;
    localparam logic [3:0] F_RET  = 4'b0001;
    localparam logic [3:0] F_CALL = 4'b0010;
    localparam logic [3:0] F_BEQ  = 4'b0000;
    localparam logic [3:0] F_BNE  = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } seq_state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_JMP,
        OP_RET,
        OP_CALL,
        OP_BEQ,
        OP_BNE,
        OP_ILLEGAL,
        OP_DISPATCH
    } op_e;

    // Decides whether a word is resolved locally, rejected, or handed downstream.
    function automatic op_e classify(input logic [INSTR_BITS-1:0] w);
        logic [2:0] typ;
        logic [3:0] func;
        op_e        op;
        typ  = w[TYPE_MSB:TYPE_LSB];
        func = w[FUNC_MSB:FUNC_LSB];
        if (w == '0) begin
            op = OP_NOP;
        end else if (typ == TYPE_CTRL) begin
            case (func)
                F_JMP:   op = OP_JMP;
                F_RET:   op = OP_RET;
                F_CALL:  op = OP_CALL;
                default: op = OP_ILLEGAL;
            endcase
        end else if (typ == TYPE_BRANCH) begin
            case (func)
                F_BEQ:   op = OP_BEQ;
                F_BNE:   op = OP_BNE;
                default: op = OP_ILLEGAL;
            endcase
        end else begin
            op = OP_DISPATCH;
        end
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of CALL return addresses; push and pop are ignored when full/empty,
// the sequencer checks full/empty itself and raises the error.
module return_stack #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [AW-1:0]     rd_idx;

    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign rd_idx   = sp_q[AW-1:0] - AW'(1);
    assign pop_data = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: storage has no reset; entries are only read below sp, which is
    // always written first, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing core: owns PC, IR and the call stack, resolves
// jumps, calls, returns and branches, and dispatches everything else.
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 4,
    parameter int INSTR_W     = 19,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction_code,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [3:0]         cmp_ra,
    output logic [3:0]         cmp_rb,
    input  logic               cmp_eq,
    output logic               busy,
    output logic               halted,
    output logic               error
);

    seq_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;

    logic               stk_push, stk_pop;
    logic               stk_full, stk_empty;
    logic [PC_W-1:0]    stk_top;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    target;
    op_e                exec_op;

    assign pc_inc  = pc_q + PC_W'(1);
    assign target  = PC_W'(ir_q[TGT_MSB:TGT_LSB]);
    assign exec_op = classify(ir_q);

    return_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (PC_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .pop_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // NOTE: every signal gets its hold value before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        error_d  = error_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instruction_code;
                valid_d = (classify(instruction_code) == OP_DISPATCH);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (exec_op)
                    OP_NOP: pc_d = pc_inc;
                    OP_JMP: pc_d = target;
                    OP_CALL: begin
                        if (stk_full) begin
                            error_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            error_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_top;
                        end
                    end
                    OP_BEQ: pc_d = cmp_eq ? target : pc_inc;
                    OP_BNE: pc_d = cmp_eq ? pc_inc : target;
                    OP_ILLEGAL: begin
                        error_d = 1'b1;
                        state_d = S_HALT;
                    end
                    OP_DISPATCH: begin
                        // IR is the output register, so it stays stable while stalled.
                        if (instr_ready) begin
                            pc_d    = pc_inc;
                            valid_d = 1'b0;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT: ;
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign pc          = pc_q;
    assign instr_out   = ir_q;
    assign instr_valid = valid_q;
    assign cmp_ra      = ir_q[RA_MSB:RA_LSB];
    assign cmp_rb      = ir_q[RB_MSB:RB_LSB];
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign error       = error_q;

endmodule
